// File: rtl/fact_sched.sv
// Round-robin scheduler sharing one memory-mapped factorial accelerator among NREQ requesters.
// Optional poll watchdog with a timeout output port: define FACT_SCHED_TIMEOUT_EN.
module fact_sched #(
    parameter int NREQ  = 2,
    parameter int PTR_W = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [4*NREQ-1:0]   n_in,
    output logic [NREQ-1:0]     ack,
    output logic [31:0]         res,
    output logic                err,
    output logic                busy,
    output logic [1:0]          fa,
    output logic                fwe,
    output logic [3:0]          fwd,
    input  logic [31:0]         frd
`ifdef FACT_SCHED_TIMEOUT_EN
    , output logic              timeout
`endif
);

    localparam int NP = 1 << PTR_W;
    localparam int NW = 4 * NP;

    typedef enum logic [2:0] {
        IDLE, WR_N, WR_GO, SETTLE, POLL, RD_RES, RESP
    } state_t;

    state_t               state_q;
    logic [PTR_W-1:0]     ptr_q;
    logic [PTR_W-1:0]     g_q;
    logic                 settle_q;
    logic [NREQ-1:0]      ack_q;
    logic [31:0]          res_q;
    logic                 err_q;
    logic                 busy_q;
    logic [1:0]           fa_q;
    logic                 fwe_q;
    logic [3:0]           fwd_q;
`ifdef FACT_SCHED_TIMEOUT_EN
    logic [15:0]          cnt_q;
    logic                 to_q;
`endif

    // Padding to a power of two lets the pointer index the vectors without width mismatches.
    logic [NP-1:0]        req_pad;
    logic [NW-1:0]        n_pad;
    logic                 found_d;
    logic [PTR_W-1:0]     win_d;
    logic [3:0]           n_sel_d;

    assign req_pad = NP'(req);
    assign n_pad   = NW'(n_in);
    assign n_sel_d = n_pad[{win_d, 2'b00} +: 4];

    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return s[PTR_W-1:0];
    endfunction

    always_comb begin
        found_d = 1'b0;
        win_d   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found_d && req_pad[wrap_idx(ptr_q, k)]) begin
                found_d = 1'b1;
                win_d   = wrap_idx(ptr_q, k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            g_q      <= '0;
            settle_q <= 1'b0;
            ack_q    <= '0;
            res_q    <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            fa_q     <= 2'd0;
            fwe_q    <= 1'b0;
            fwd_q    <= 4'd0;
`ifdef FACT_SCHED_TIMEOUT_EN
            cnt_q    <= '0;
            to_q     <= 1'b0;
`endif
        end else begin
            ack_q <= '0;
`ifdef FACT_SCHED_TIMEOUT_EN
            to_q  <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        g_q     <= win_d;
                        ptr_q   <= wrap_idx(win_d, 1);
                        state_q <= WR_N;
                        busy_q  <= 1'b1;
                        fa_q    <= 2'd0;
                        fwe_q   <= 1'b1;
                        fwd_q   <= n_sel_d;
                    end
                end
                WR_N: begin
                    state_q <= WR_GO;
                    fa_q    <= 2'd1;
                    fwe_q   <= 1'b1;
                    fwd_q   <= 4'b0001;
                end
                WR_GO: begin
                    state_q  <= SETTLE;
                    settle_q <= 1'b0;
                    fwe_q    <= 1'b0;
                    fwd_q    <= 4'd0;
                end
                // Two idle cycles so a done left over from the previous job has been cleared.
                SETTLE: begin
                    if (settle_q) begin
                        state_q <= POLL;
                        fa_q    <= 2'd2;
`ifdef FACT_SCHED_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end else begin
                        settle_q <= 1'b1;
                    end
                end
                POLL: begin
                    if (frd[0] || frd[1]) begin
                        err_q   <= frd[1];
                        state_q <= RD_RES;
                        fa_q    <= 2'd3;
                    end
`ifdef FACT_SCHED_TIMEOUT_EN
                    else if (cnt_q == 16'hFFFF) begin
                        err_q   <= 1'b1;
                        res_q   <= 32'hFFFF_FFFF;
                        state_q <= RESP;
                        ack_q   <= NREQ'(1) << g_q;
                        to_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
`endif
                end
                RD_RES: begin
                    res_q   <= frd;
                    state_q <= RESP;
                    ack_q   <= NREQ'(1) << g_q;
                end
                RESP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    fa_q    <= 2'd0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack  = ack_q;
    assign res  = res_q;
    assign err  = err_q;
    assign busy = busy_q;
    assign fa   = fa_q;
    assign fwe  = fwe_q;
    assign fwd  = fwd_q;
`ifdef FACT_SCHED_TIMEOUT_EN
    assign timeout = to_q;
`endif

endmodule

// File: tb/tb_fact_sched.sv
// Bench for fact_sched: behavioural accelerator stub, result scoreboard, table of jobs, corner sequences.
module tb_fact_sched;
    localparam int NREQ = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [4*NREQ-1:0] n_in = '0;
    logic [NREQ-1:0]   ack;
    logic [31:0]       res;
    logic              err;
    logic              busy;
    logic [1:0]        fa;
    logic              fwe;
    logic [3:0]        fwd;
    logic [31:0]       frd;
`ifdef FACT_SCHED_TIMEOUT_EN
    logic              timeout;
`endif

    always #5 clk = ~clk;

    fact_sched #(.NREQ(NREQ), .PTR_W(2)) dut (
        .clk(clk), .rst(rst), .req(req), .n_in(n_in), .ack(ack), .res(res), .err(err),
        .busy(busy), .fa(fa), .fwe(fwe), .fwd(fwd), .frd(frd)
`ifdef FACT_SCHED_TIMEOUT_EN
        , .timeout(timeout)
`endif
    );

    // Accelerator stub: go is registered twice before done clears, so a stale done lingers two cycles.
    logic [3:0]  a_n = 4'd0;
    logic        go1 = 1'b0, go2 = 1'b0, a_done = 1'b1, a_err = 1'b0, a_run = 1'b0;
    logic [31:0] a_res = 32'hDEAD_BEEF;
    int          a_cnt = 0;
    int          lat = 0;
    bit          stall = 1'b0;

    function automatic longint fact(input int n);
        longint f = 1;
        for (int i = 2; i <= n; i++) f = f * i;
        return f;
    endfunction

    always @(posedge clk) begin
        go1 <= fwe && (fa == 2'd1) && fwd[0];
        go2 <= go1;
        if (fwe && fa == 2'd0) a_n <= fwd;
        if (go2) begin
            a_done <= 1'b0;
            a_err  <= 1'b0;
            a_cnt  <= lat;
            a_run  <= 1'b1;
        end else if (a_run) begin
            if (a_cnt != 0) a_cnt <= a_cnt - 1;
            else if (!stall) begin
                a_run <= 1'b0;
                if (fact(int'(a_n)) > 64'hFFFF_FFFF) begin
                    a_err <= 1'b1;
                    a_res <= 32'd0;
                end else begin
                    a_done <= 1'b1;
                    a_res  <= 32'(fact(int'(a_n)));
                end
            end
        end
    end

    always_comb begin
        frd = 32'd0;
        case (fa)
            2'd0: frd = {28'd0, a_n};
            2'd2: frd = {30'd0, a_err, a_done};
            2'd3: frd = a_res;
            default: frd = 32'd0;
        endcase
    end

    typedef struct {
        int          idx;
        logic [31:0] res;
        logic        err;
        logic        to;
    } exp_t;
    exp_t sbq[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_ack_cyc = -100;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, want);
        end
    endtask

    // Scoreboard monitor: every ack pops one expectation.
    always @(negedge clk) begin
        if (ack != '0) begin
            exp_t e;
            check("ack_onehot", 32'($onehot(ack)), 32'd1);
            check("ack_gap_ge8", 32'(cyc - last_ack_cyc >= 8), 32'd1);
            last_ack_cyc = cyc;
            if (sbq.size() == 0) begin
                check("unexpected_ack", 32'(ack), 32'd0);
            end else begin
                e = sbq.pop_front();
                check("ack_idx", 32'(ack), 32'(1) << e.idx);
                check("res", res, e.res);
                check("err", 32'(err), 32'(e.err));
`ifdef FACT_SCHED_TIMEOUT_EN
                check("timeout", 32'(timeout), 32'(e.to));
`endif
            end
        end
    end

    task automatic push(input int idx, input logic [31:0] r, input logic e, input logic to);
        exp_t x;
        x.idx = idx; x.res = r; x.err = e; x.to = to;
        sbq.push_back(x);
    endtask

    // Drive one job, hold req until ack, optionally check req-to-ack latency.
    task automatic run_job(input int idx, input logic [3:0] n, input logic [31:0] r,
                           input logic e, input int exp_lat);
        int k;
        @(negedge clk);
        n_in[4*idx +: 4] = n;
        req[idx] = 1'b1;
        push(idx, r, e, 1'b0);
        k = 0;
        while (k < 400) begin
            @(negedge clk);
            k++;
            if (ack[idx]) break;
        end
        req[idx] = 1'b0;
        if (exp_lat >= 0) check("latency", 32'(k), 32'(exp_lat));
        else check("ack_seen", 32'(k < 400), 32'd1);
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (sbq.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("sb_drained", 32'(sbq.size()), 32'd0);
        sbq.delete();
    endtask

    typedef struct {
        int          idx;
        logic [3:0]  n;
        int          lat;
        logic [31:0] eres;
        logic        eerr;
    } vec_t;
    vec_t tbl[6];

    initial begin
        int k;
        int nack;
        tbl[0] = '{0, 4'd3,  2, 32'd6,         1'b0};
        tbl[1] = '{1, 4'd15, 1, 32'd0,         1'b1};
        tbl[2] = '{1, 4'd2,  3, 32'd2,         1'b0};
        tbl[3] = '{0, 4'd0,  0, 32'd1,         1'b0};
        tbl[4] = '{1, 4'd12, 4, 32'd479001600, 1'b0};
        tbl[5] = '{0, 4'd13, 0, 32'd0,         1'b1};

        repeat (3) @(negedge clk);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_res", res, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fa", 32'(fa), 32'd0);
        check("rst_fwe", 32'(fwe), 32'd0);
        check("rst_fwd", 32'(fwd), 32'd0);
        rst = 1'b0;

        // Single job with bus sequence checks.
        @(negedge clk);
        lat = 2;
        n_in[3:0] = 4'd3;
        req[0] = 1'b1;
        push(0, 32'd6, 1'b0, 1'b0);
        @(negedge clk);
        check("wrn_fa", 32'(fa), 32'd0);
        check("wrn_fwe", 32'(fwe), 32'd1);
        check("wrn_fwd", 32'(fwd), 32'd3);
        check("wrn_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("wrgo_fa", 32'(fa), 32'd1);
        check("wrgo_fwe", 32'(fwe), 32'd1);
        check("wrgo_fwd", 32'(fwd), 32'd1);
        @(negedge clk);
        check("settle_fwe", 32'(fwe), 32'd0);
        check("settle_fwd", 32'(fwd), 32'd0);
        check("settle_busy", 32'(busy), 32'd1);
        k = 0;
        while (!ack[0] && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("single_ack_seen", 32'(k < 200), 32'd1);
        check("resp_busy", 32'(busy), 32'd1);
        req[0] = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        wait_drain(50);

        // Table of jobs, each with its own accelerator latency.
        for (int i = 0; i < 6; i++) begin
            lat = tbl[i].lat;
            run_job(tbl[i].idx, tbl[i].n, tbl[i].eres, tbl[i].eerr, 8 + tbl[i].lat);
        end
        wait_drain(50);

        // Contention from ptr=0 after a reset pulse.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        lat = 1;
        n_in = {4'd5, 4'd4};
        req = 2'b11;
        push(0, 32'd24, 1'b0, 1'b0);
        push(1, 32'd120, 1'b0, 1'b0);
        k = 0;
        while (req != '0 && k < 400) begin
            @(negedge clk);
            k++;
            if (ack[0]) req[0] = 1'b0;
            if (ack[1]) req[1] = 1'b0;
        end
        req = '0;
        wait_drain(50);

        // Fairness: both held for four jobs.
        @(negedge clk);
        req = 2'b11;
        push(0, 32'd24, 1'b0, 1'b0);
        push(1, 32'd120, 1'b0, 1'b0);
        push(0, 32'd24, 1'b0, 1'b0);
        push(1, 32'd120, 1'b0, 1'b0);
        nack = 0;
        k = 0;
        while (nack < 4 && k < 800) begin
            @(negedge clk);
            k++;
            if (ack != '0) nack++;
        end
        req = '0;
        wait_drain(50);

        // Reset during POLL with a stalled accelerator: no ack may appear.
        stall = 1'b1;
        @(negedge clk);
        n_in[3:0] = 4'd6;
        req[0] = 1'b1;
        k = 0;
        while (!(busy && fa == 2'd2) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("reached_poll", 32'(k < 100), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ack", 32'(ack), 32'd0);
        check("mid_rst_fa", 32'(fa), 32'd0);
        rst = 1'b0;
        req[0] = 1'b0;
        stall = 1'b0;
        lat = 0;
        run_job(1, 4'd7, 32'd5040, 1'b0, 8);
        wait_drain(50);

`ifdef FACT_SCHED_TIMEOUT_EN
        stall = 1'b1;
        @(negedge clk);
        n_in[3:0] = 4'd3;
        req[0] = 1'b1;
        push(0, 32'hFFFF_FFFF, 1'b1, 1'b1);
        k = 0;
        while (!ack[0] && k < 70000) begin
            @(negedge clk);
            k++;
        end
        check("timeout_ack_seen", 32'(k < 70000), 32'd1);
        req[0] = 1'b0;
        stall = 1'b0;
        wait_drain(50);
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog got=expired want=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fact_sched.md
Name: fact_sched

Overview:
- Round-robin scheduler that shares one memory-mapped factorial accelerator (fact_top) among NREQ requesters.
- Arbitrates pending requests and grants one requester at a time.
- For the granted job it drives the accelerator register bus: writes n, writes go, polls status, then reads the result.
- Returns result/err to the winning requester with a one-cycle ack. Sits between client masters (CPU-side units) and fact_top.

Parameters:
- NREQ, 2, number of requesters (2..4).
- PTR_W, 2, width of round-robin pointer; must satisfy 2**PTR_W >= NREQ.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  NREQ  per-requester request level
- n_in  input  4*NREQ  operand n for requester i at bits [4i+3:4i]
- ack  output  NREQ  one-cycle completion pulse, one-hot
- res  output  32  result, valid only while any ack bit is high
- err  output  1  accelerator error flag, valid with ack
- busy  output  1  high while a job is in progress (state != IDLE)
- fa  output  2  accelerator address: 0=n, 1=go, 2=status{err,done}, 3=result
- fwe  output  1  accelerator write enable
- fwd  output  4  accelerator write data
- frd  input  32  accelerator read data; combinational on fa

Behaviour:
- Interface decided: one clock; reset is synchronous and active-high; ports named clk and rst.
- Reset: state=IDLE, ptr=0, ack=0, res=0, err=0, busy=0, fa=0, fwe=0, fwd=0.
- Requester handshake:
  - Requester raises req[i] with n_in stable and holds both until ack[i].
  - A requester deasserting req before ack is a protocol violation; the job still completes and ack still pulses.
- Arbitration, in IDLE:
  - Search starts at ptr, wraps modulo NREQ; the first set req wins.
  - Latch winner index g and its n.
  - ptr <= (g+1) mod NREQ, applied at grant.
  - No req set: stay in IDLE.
- FSM states (one cycle each unless noted):
  - IDLE: grant as above; transition to WR_N.
  - WR_N: fa=0, fwe=1, fwd=latched n.
  - WR_GO: fa=1, fwe=1, fwd=4'b0001.
  - SETTLE: 2 cycles, fwe=0. Lets the accelerator's registered go pulse and done clear take effect; a stale done must never be sampled.
  - POLL: fa=2, fwe=0.
    - frd[0]=1 (done) or frd[1]=1 (err): latch err<=frd[1], go to RD_RES.
    - Otherwise stay in POLL.
  - RD_RES: fa=3. Latch res<=frd, go to RESP.
  - RESP: ack[g]=1 for exactly this cycle; res/err held. Go to IDLE.
- res and err hold their values until the next RESP overwrites them; consumers sample only while ack is high.
- fwe is high only in WR_N and WR_GO. In all other states fwd=0 and fa holds the state's address.
- Minimum latency from req (sampled in IDLE) to ack: 1+1+1+2+1+1+1 = 8 cycles plus (poll cycles - 1).
- A new req arriving during a job waits; back-to-back jobs have one IDLE cycle between RESP and the next WR_N.
- rst mid-job: on the same edge, return to IDLE with all outputs reset. No ack is issued; the accelerator is not rewritten. The aborted requester must re-request after rst deasserts, with ptr=0.

Optional Feature:
- Macro: FACT_SCHED_TIMEOUT_EN.
- With the macro defined:
  - A 16-bit poll counter clears on entry to POLL and increments each POLL cycle.
  - At 16'hFFFF without done/err: skip RD_RES, go to RESP with err=1 and res=32'hFFFF_FFFF.
  - Port timeout (output, 1) pulses high together with that ack.
- Without the macro: no counter, no timeout port; POLL waits indefinitely.

Test Plan:
- Single job: req[0]=1, n=3 -> bus shows fa0/fwd3, then fa1/fwd1; ack[0] pulses with res=6, err=0; busy high from WR_N through RESP.
- Error: req[1]=1, n=15 with accelerator flagging overflow -> ack[1] with err=1; next job n=2 returns res=2, err=0 (err cleared).
- Contention: req[0] and req[1] raised same cycle at ptr=0 -> requester 0 served first (n=4, res=24), then requester 1 (n=5, res=120). Acks are one-hot, separated by at least 8 cycles.
- Fairness: both req held continuously for 4 jobs -> ack order 0,1,0,1; ptr wraps correctly.
- Reset mid-POLL: assert rst during POLL -> next cycle IDLE, busy=0, no ack. After release, req[1] is served ahead of req[0] only if req[0] is low.
- Timeout (macro defined, accelerator stub never sets done) -> ack with err=1, res=32'hFFFF_FFFF, timeout=1 after 65536 POLL cycles.
